// File: rtl/fmul_float_issue_queue.sv
// fmul_float_issue_queue
//   Operand issue queue and in-order tag tracker sitting in front of the
//   fmul_float pipeline. Operand pairs are buffered in a small FIFO and issued
//   under REQ/BUSY flow control; the tag of every issued pair is recorded and
//   re-attached to the matching result, which leaves through a registered stage.
//
// Ports
//   iCLOCK, iRESET (async, active-high), iRESET_SYNC (synchronous clear)
//   Requester : iREQ, oBUSY, iTAG, iDATA_A, iDATA_B
//   Multiplier: oMUL_REQ, iMUL_BUSY, oMUL_DATA_A, oMUL_DATA_B,
//               iMUL_VALID, oMUL_BUSY, iMUL_DATA
//   Consumer  : oVALID, iBUSY, oTAG, oDATA
//   Status    : oINFLIGHT (tag FIFO occupancy), oERR_UNDERFLOW (sticky)
//
// Build option
//   FMUL_ISSUE_BYPASS_EN : when defined, a pair offered to an empty operand FIFO
//   issues combinationally in the same cycle without being written.

module fmul_float_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int INFLIGHT = 8
) (
  input  logic                          iCLOCK,
  input  logic                          iRESET,
  input  logic                          iRESET_SYNC,
  input  logic                          iREQ,
  output logic                          oBUSY,
  input  logic [TAG_W-1:0]              iTAG,
  input  logic [31:0]                   iDATA_A,
  input  logic [31:0]                   iDATA_B,
  output logic                          oMUL_REQ,
  input  logic                          iMUL_BUSY,
  output logic [31:0]                   oMUL_DATA_A,
  output logic [31:0]                   oMUL_DATA_B,
  input  logic                          iMUL_VALID,
  output logic                          oMUL_BUSY,
  input  logic [31:0]                   iMUL_DATA,
  output logic                          oVALID,
  input  logic                          iBUSY,
  output logic [TAG_W-1:0]              oTAG,
  output logic [31:0]                   oDATA,
  output logic [$clog2(INFLIGHT):0]     oINFLIGHT,
  output logic                          oERR_UNDERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(INFLIGHT);
  localparam int IW = $clog2(INFLIGHT) + 1;

  // Operand FIFO
  logic [TAG_W-1:0] op_tag [DEPTH];
  logic [31:0]      op_a   [DEPTH];
  logic [31:0]      op_b   [DEPTH];
  logic [PW-1:0]    op_wr, op_rd;
  logic [CW-1:0]    op_cnt;

  // Tag FIFO
  logic [TAG_W-1:0] tag_mem [INFLIGHT];
  logic [TW-1:0]    tag_wr, tag_rd;
  logic [IW-1:0]    inflight;

  logic             op_full, op_empty, room;
  logic             push, push_fifo, pop_fifo, issue;
  logic             res_stall, res_accept, capture, underflow;
  logic [TAG_W-1:0] head_tag;

  assign op_full   = (op_cnt == CW'(DEPTH));
  assign op_empty  = (op_cnt == '0);
  // Strict gating: a full tag FIFO blocks issue even if a tag pops this cycle.
  assign room      = (inflight < IW'(INFLIGHT));
  assign push      = iREQ && !op_full;

  always_comb begin
    oMUL_REQ    = 1'b0;
    oMUL_DATA_A = op_a[op_rd];
    oMUL_DATA_B = op_b[op_rd];
    head_tag    = op_tag[op_rd];
    issue       = 1'b0;
    push_fifo   = 1'b0;
    pop_fifo    = 1'b0;
`ifdef FMUL_ISSUE_BYPASS_EN
    // An empty FIFO exposes the live input as its head; if that pair issues
    // immediately it is never written.
    if (op_empty) begin
      oMUL_DATA_A = iDATA_A;
      oMUL_DATA_B = iDATA_B;
      head_tag    = iTAG;
    end
    oMUL_REQ  = (!op_empty || iREQ) && room;
    issue     = oMUL_REQ && !iMUL_BUSY;
    push_fifo = push && !(op_empty && issue);
    pop_fifo  = issue && !op_empty;
`else
    oMUL_REQ  = !op_empty && room;
    issue     = oMUL_REQ && !iMUL_BUSY;
    push_fifo = push;
    pop_fifo  = issue;
`endif
  end

  assign oBUSY      = op_full;
  assign res_stall  = oVALID && iBUSY;
  assign oMUL_BUSY  = res_stall;
  assign res_accept = iMUL_VALID && !res_stall;
  assign capture    = res_accept && (inflight != '0);
  assign underflow  = res_accept && (inflight == '0);
  assign oINFLIGHT  = inflight;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_tag[i] <= '0;
        op_a[i]   <= '0;
        op_b[i]   <= '0;
      end
      for (int unsigned i = 0; i < INFLIGHT; i++) tag_mem[i] <= '0;
      op_wr          <= '0;
      op_rd          <= '0;
      op_cnt         <= '0;
      tag_wr         <= '0;
      tag_rd         <= '0;
      inflight       <= '0;
      oVALID         <= 1'b0;
      oTAG           <= '0;
      oDATA          <= '0;
      oERR_UNDERFLOW <= 1'b0;
    end else if (iRESET_SYNC) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_tag[i] <= '0;
        op_a[i]   <= '0;
        op_b[i]   <= '0;
      end
      for (int unsigned i = 0; i < INFLIGHT; i++) tag_mem[i] <= '0;
      op_wr          <= '0;
      op_rd          <= '0;
      op_cnt         <= '0;
      tag_wr         <= '0;
      tag_rd         <= '0;
      inflight       <= '0;
      oVALID         <= 1'b0;
      oTAG           <= '0;
      oDATA          <= '0;
      oERR_UNDERFLOW <= 1'b0;
    end else begin
      if (push_fifo) begin
        op_tag[op_wr] <= iTAG;
        op_a[op_wr]   <= iDATA_A;
        op_b[op_wr]   <= iDATA_B;
        op_wr         <= op_wr + 1'b1;
      end
      if (pop_fifo) op_rd <= op_rd + 1'b1;
      case ({push_fifo, pop_fifo})
        2'b10:   op_cnt <= op_cnt + 1'b1;
        2'b01:   op_cnt <= op_cnt - 1'b1;
        default: op_cnt <= op_cnt;
      endcase

      if (issue) begin
        tag_mem[tag_wr] <= head_tag;
        tag_wr          <= tag_wr + 1'b1;
      end
      if (capture) tag_rd <= tag_rd + 1'b1;
      case ({issue, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (capture) begin
        oDATA  <= iMUL_DATA;
        oTAG   <= tag_mem[tag_rd];
        oVALID <= 1'b1;
      end else if (oVALID && !iBUSY) begin
        oVALID <= 1'b0;
      end

      if (underflow) oERR_UNDERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fmul_float_issue_queue.sv
// Scoreboard bench for fmul_float_issue_queue. A behavioural in-order
// multiplier (fixed latency) sits behind the queue; expected {tag, product}
// pairs come from a hand-computed vector table and are queued at acceptance,
// then popped by an independent monitor whenever a result is consumed.

module tb_fmul_float_issue_queue;

  localparam int DEPTH    = 4;
  localparam int TAG_W    = 4;
  localparam int INFLIGHT = 8;
  localparam int LAT      = 4;

  logic        clk = 1'b0;
  logic        rst, rst_sync, req, mul_busy, mul_valid, busy;
  logic [3:0]  tag;
  logic [31:0] a, b, mul_data;
  logic        obusy, mul_req, omul_busy, ovalid, err;
  logic [31:0] mul_a, mul_b, odata;
  logic [3:0]  otag;
  logic [3:0]  oinflight;

  always #5 clk = ~clk;

  fmul_float_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .INFLIGHT(INFLIGHT)) dut (
    .iCLOCK(clk), .iRESET(rst), .iRESET_SYNC(rst_sync),
    .iREQ(req), .oBUSY(obusy), .iTAG(tag), .iDATA_A(a), .iDATA_B(b),
    .oMUL_REQ(mul_req), .iMUL_BUSY(mul_busy), .oMUL_DATA_A(mul_a), .oMUL_DATA_B(mul_b),
    .iMUL_VALID(mul_valid), .oMUL_BUSY(omul_busy), .iMUL_DATA(mul_data),
    .oVALID(ovalid), .iBUSY(busy), .oTAG(otag), .oDATA(odata),
    .oINFLIGHT(oinflight), .oERR_UNDERFLOW(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-computed IEEE-754 single products
  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [31:0] ve [8];
  initial begin
    va[0] = 32'h3F800000; vb[0] = 32'h40000000; ve[0] = 32'h40000000; // 1*2=2
    va[1] = 32'h40000000; vb[1] = 32'h40400000; ve[1] = 32'h40C00000; // 2*3=6
    va[2] = 32'h3F000000; vb[2] = 32'h41200000; ve[2] = 32'h40A00000; // 0.5*10=5
    va[3] = 32'hC0000000; vb[3] = 32'h3FC00000; ve[3] = 32'hC0400000; // -2*1.5=-3
    va[4] = 32'h40800000; vb[4] = 32'h3E800000; ve[4] = 32'h3F800000; // 4*0.25=1
    va[5] = 32'hBF800000; vb[5] = 32'hBF800000; ve[5] = 32'h3F800000; // -1*-1=1
    va[6] = 32'h41000000; vb[6] = 32'h42C80000; ve[6] = 32'h44480000; // 8*100=800
    va[7] = 32'h3F800000; vb[7] = 32'h00000000; ve[7] = 32'h00000000; // 1*0=0
  end

  // Multiplier model, valid only when one operand is a power of two (all table entries)
  function automatic logic [31:0] fmul_model(input logic [31:0] x, input logic [31:0] y);
    logic [7:0] e;
    if (x[30:0] == 31'd0 || y[30:0] == 31'd0) return {x[31] ^ y[31], 31'd0};
    e = x[30:23] + y[30:23] - 8'd127;
    return {x[31] ^ y[31], e, x[22:0] | y[22:0]};
  endfunction

  typedef struct { logic [31:0] d; int ic; } mq_t;
  mq_t          mq[$];
  logic [35:0]  sb[$];
  int           cyc = 0;
  logic         inj = 1'b0;
  logic [31:0]  inj_data = '0;
  int           bmode = 0;

  // In-order pipelined multiplier
  initial begin : mul_model
    logic        i_fire, m_fire;
    logic [31:0] ia, ib;
    mul_valid = 1'b0;
    mul_data  = '0;
    forever begin
      @(negedge clk);
      i_fire = mul_req && !mul_busy && !rst && !rst_sync;
      ia = mul_a;
      ib = mul_b;
      m_fire = mul_valid && !omul_busy && !rst && !rst_sync && !inj;
      @(posedge clk);
      cyc++;
      #1;
      if (i_fire) mq.push_back('{fmul_model(ia, ib), cyc});
      if (m_fire && mq.size() > 0) void'(mq.pop_front());
      if (inj) begin
        mul_valid = 1'b1;
        mul_data  = inj_data;
      end else if (mq.size() > 0 && (cyc - mq[0].ic) >= LAT) begin
        mul_valid = 1'b1;
        mul_data  = mq[0].d;
      end else begin
        mul_valid = 1'b0;
        mul_data  = '0;
      end
    end
  end

  // Consumer stall pattern: 0 none, 1 held, 2 toggling
  initial begin : consumer
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      busy = (bmode == 1) ? 1'b1 : (bmode == 2) ? ~busy : 1'b0;
    end
  end

  // Monitor
  int          res_n = 0, first_c = -1, last_c = 0, max_inf = 0;
  logic        prev_hold = 1'b0;
  logic [3:0]  prev_tag;
  logic [31:0] prev_data;
  initial begin : monitor
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          chk("hold_stable", {ovalid, otag, odata}, {1'b1, prev_tag, prev_data});
        if (ovalid && !busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected none", {otag, odata});
          end else begin
            e = sb.pop_front();
            chk("result", {otag, odata}, e);
          end
          res_n++;
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
        end
        prev_hold = ovalid && busy;
        prev_tag  = otag;
        prev_data = odata;
        if (int'(oinflight) > max_inf) max_inf = int'(oinflight);
      end
    end
  end

  task automatic offer(input logic [3:0] t, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ex);
    int  n = 0;
    bit  done = 0;
    req = 1'b1; tag = t; a = x; b = y;
    while (!done && n < 200) begin
      @(negedge clk);
      if (!obusy) begin
        sb.push_back({t, ex});
        done = 1;
      end else begin
        n++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got busy expected accept tag=%0d", t);
    end
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin : main
    rst = 1'b1; rst_sync = 1'b0; req = 1'b0; tag = '0; a = '0; b = '0; mul_busy = 1'b0;
    #12;
    chk("rst_valid", ovalid, 0);
    chk("rst_busy", obusy, 0);
    chk("rst_mul_req", mul_req, 0);
    chk("rst_inflight", oinflight, 0);
    chk("rst_err", err, 0);
    chk("rst_data", odata, 0);
    chk("rst_tag", otag, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single op: 1.0 * 2.0, tag 3
    chk("req_before_push", mul_req, 0);
    offer(4'd3, 32'h3F800000, 32'h40000000, 32'h40000000);
    chk("req_after_push", mul_req, 1);
    drain();
    chk("single_inflight_idle", oinflight, 0);

    // Stream of 16, no stalls
    res_n = 0; first_c = -1; max_inf = 0;
    for (int i = 0; i < 16; i++) offer(4'(i), va[i % 8], vb[i % 8], ve[i % 8]);
    drain();
    chk("stream_count", res_n, 16);
    chk("stream_no_bubble", last_c - first_c, 15);
    chk("stream_inflight_max", max_inf <= INFLIGHT, 1);

    // Consumer held: tag FIFO saturates, operand FIFO fills
    bmode = 1;
    repeat (2) @(posedge clk);
    #1;
    res_n = 0;
    for (int i = 0; i < 13; i++) offer(4'(i + 2), va[(i + 3) % 8], vb[(i + 3) % 8], ve[(i + 3) % 8]);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_inflight", oinflight, INFLIGHT);
    chk("sat_full_busy", obusy, 1);
    chk("sat_mul_busy", omul_busy, 1);
    chk("sat_no_issue", mul_req, 0);
    bmode = 0;
    drain();
    chk("sat_count", res_n, 13);
    chk("sat_inflight_idle", oinflight, 0);

    // Consumer toggling every cycle
    bmode = 2;
    res_n = 0;
    for (int i = 0; i < 8; i++) offer(4'(i + 8), va[7 - i], vb[7 - i], ve[7 - i]);
    drain();
    chk("toggle_count", res_n, 8);
    bmode = 0;
    repeat (2) @(posedge clk);

    // Result with no tag outstanding
    #2 inj_data = 32'h12345678; inj = 1'b1;
    @(posedge clk);
    #2 inj = 1'b0;
    @(posedge clk);
    #1;
    chk("uf_valid", ovalid, 0);
    chk("uf_err", err, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("uf_sticky", err, 1);
    rst_sync = 1'b1;
    @(posedge clk);
    #1;
    rst_sync = 1'b0;
    chk("sync_clear_err", err, 0);
    chk("sync_clear_inflight", oinflight, 0);

    // Async reset with 3 queued and 2 in flight
    offer(4'd1, va[1], vb[1], ve[1]);
    offer(4'd2, va[2], vb[2], ve[2]);
    offer(4'd3, va[3], vb[3], ve[3]);
    mul_busy = 1'b1;
    offer(4'd4, va[4], vb[4], ve[4]);
    offer(4'd5, va[5], vb[5], ve[5]);
    chk("pre_reset_inflight", oinflight, 2);
    chk("pre_reset_req", mul_req, 1);
    #2 rst = 1'b1;
    sb.delete();
    mq.delete();
    #1;
    chk("arst_valid", ovalid, 0);
    chk("arst_busy", obusy, 0);
    chk("arst_inflight", oinflight, 0);
    chk("arst_mul_req", mul_req, 0);
    mul_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    offer(4'd9, va[1], vb[1], ve[1]);
    drain();
    chk("post_reset_inflight", oinflight, 0);
    chk("post_reset_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
